// File: rtl/stim_rx_pkg.sv
// Shared types and line levels for the stim_rx_drv UART-style frame driver.
// Optional macro: STIM_RX_DRV_PARITY_EN adds the PARITY state to the enum.
package stim_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef STIM_RX_DRV_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/stim_bit_tmr.sv
// Bit-period timer: counts 0..prescale-1 while running and pulses bit_end on
// the last cycle of each bit. A prescale of 0 is stretched to 1 cycle.
// load holds the counter at zero (used while the driver is idle).
module stim_bit_tmr #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_end
);

  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] last;

  // Terminal count; zero prescale behaves like one cycle per bit
  always_comb begin
    last = '0;
    if (prescale != '0) last = prescale - PRESCALE_W'(1);
  end

  assign bit_end = !load && (cnt == last);

  // Cycle counter within the current bit, restarting at every bit boundary
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/stim_rx_drv.sv
// Serial frame driver feeding a UART receiver under test: start bit, data
// LSB first, optional parity, stop bit, each held for the latched PRESCALE.
// Optional macro: STIM_RX_DRV_PARITY_EN enables the parity bit (PAR_EN /
// PAR_TYP); without it those ports are ignored and frames carry no parity.
// Handshake: TX_VLD is a request sampled only in IDLE (BUSY=0); requests while
// BUSY=1, including the DONE cycle, are dropped rather than queued.
module stim_rx_drv
  import stim_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  REF_CLK,
  input  logic                  RST_REF,
  input  logic [DATA_WIDTH-1:0] TX_IN,
  input  logic                  TX_VLD,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  S_DATA,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [PRESCALE_W-1:0] ps_q;
  logic [IDX_W-1:0]      bit_idx;
  logic                  bit_end;
  logic                  accept;
  logic                  last_bit;

`ifdef STIM_RX_DRV_PARITY_EN
  logic par_en_q;
  logic par_bit_q;
`else
  logic unused_par;
  assign unused_par = PAR_EN ^ PAR_TYP;
`endif

  assign accept   = (state == IDLE) && TX_VLD;
  assign last_bit = (bit_idx == IDX_W'(DATA_WIDTH - 1));

  stim_bit_tmr #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tmr (
    .clk      (REF_CLK),
    .rst      (RST_REF),
    .load     (state == IDLE),
    .prescale (ps_q),
    .bit_end  (bit_end)
  );

  // State register
  always_ff @(posedge REF_CLK) begin
    if (RST_REF) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and line/status outputs
  always_comb begin
    state_nxt = state;
    S_DATA    = IDLE_LEVEL;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        BUSY = 1'b0;
        if (TX_VLD) state_nxt = START;
      end
      START: begin
        S_DATA = START_LEVEL;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        S_DATA = shreg[0];
        if (bit_end && last_bit) begin
`ifdef STIM_RX_DRV_PARITY_EN
          state_nxt = par_en_q ? PARITY : STOP;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef STIM_RX_DRV_PARITY_EN
      PARITY: begin
        S_DATA = par_bit_q;
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        S_DATA = STOP_LEVEL;
        if (bit_end) begin
          DONE      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        BUSY      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Frame latches and data shifter; inputs are only looked at on acceptance
  always_ff @(posedge REF_CLK) begin
    if (RST_REF) begin
      shreg   <= '0;
      ps_q    <= '0;
      bit_idx <= '0;
`ifdef STIM_RX_DRV_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (accept) begin
      shreg   <= TX_IN;
      ps_q    <= PRESCALE;
      bit_idx <= '0;
`ifdef STIM_RX_DRV_PARITY_EN
      par_en_q  <= PAR_EN;
      par_bit_q <= (^TX_IN) ^ PAR_TYP;
`endif
    end else if ((state == DATA) && bit_end) begin
      shreg   <= shreg >> 1;
      bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_stim_rx_drv.sv
// Directed bench for stim_rx_drv: frame shape, timing, back-to-back requests,
// mid-frame reset, zero prescale, and the parity / no-parity builds.
module tb_stim_rx_drv;

  logic       REF_CLK = 1'b0;
  logic       RST_REF = 1'b1;
  logic [7:0] TX_IN   = '0;
  logic       TX_VLD  = 1'b0;
  logic [5:0] PRESCALE = '0;
  logic       PAR_EN  = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       S_DATA;
  logic       BUSY;
  logic       DONE;

  int n_checks = 0;
  int n_errors = 0;

  logic line_s [0:127];
  logic busy_s [0:127];
  logic done_s [0:127];

  stim_rx_drv #(
    .DATA_WIDTH (8),
    .PRESCALE_W (6)
  ) dut (
    .REF_CLK  (REF_CLK),
    .RST_REF  (RST_REF),
    .TX_IN    (TX_IN),
    .TX_VLD   (TX_VLD),
    .PRESCALE (PRESCALE),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .S_DATA   (S_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  // Clock
  always #5 REF_CLK = ~REF_CLK;

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends one frame, disturbs the inputs mid-frame (new data, prescale,
  // parity controls and a spurious TX_VLD), and checks the captured line
  // against exp_frame (bit 0 = first bit on the line).
  task automatic run_frame(input string tag, input logic [7:0] data, input logic [5:0] ps,
                           input logic pe, input logic pt,
                           input logic [15:0] exp_frame, input int exp_bits);
    int eff, cyc, done_cnt, done_at, bad, idx;
    eff = (ps == 0) ? 1 : int'(ps);
    @(negedge REF_CLK);
    TX_IN = data; PRESCALE = ps; PAR_EN = pe; PAR_TYP = pt; TX_VLD = 1'b1;
    @(negedge REF_CLK);
    TX_VLD = 1'b0;
    check_eq({tag, "_busy_rise"}, BUSY, 1);
    cyc = 0; done_cnt = 0; done_at = -1; bad = 0;
    while (BUSY && cyc < 4000) begin
      idx = cyc / eff;
      if (idx >= exp_bits || S_DATA !== exp_frame[idx]) bad++;
      if (DONE) begin done_cnt++; done_at = cyc; end
      if (cyc == 1) begin
        TX_IN = ~data; PRESCALE = ps + 6'd3; PAR_EN = ~pe; PAR_TYP = ~pt; TX_VLD = 1'b1;
      end
      if (cyc == 2) TX_VLD = 1'b0;
      cyc++;
      @(negedge REF_CLK);
    end
    check_eq({tag, "_len"}, cyc, exp_bits * eff);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_done_last"}, done_at, cyc - 1);
    check_eq({tag, "_bit_errs"}, bad, 0);
    check_eq({tag, "_idle_line"}, S_DATA, 1);
    check_eq({tag, "_idle_done"}, DONE, 0);
  endtask

  initial begin
    int bad, dn, bz;
    logic [9:0] ef1, ef2;

    // Reset
    repeat (3) @(negedge REF_CLK);
    check_eq("rst_line", S_DATA, 1);
    check_eq("rst_busy", BUSY, 0);
    check_eq("rst_done", DONE, 0);
    RST_REF = 1'b0;
    @(negedge REF_CLK);
    check_eq("idle_line", S_DATA, 1);
    check_eq("idle_busy", BUSY, 0);

    // 0xA5, 8 cycles/bit: line 0,1,0,1,0,0,1,0,1,1 -> 80 cycles
    run_frame("a5", 8'hA5, 6'd8, 1'b0, 1'b0, {1'b1, 8'hA5, 1'b0}, 10);

    // Zero prescale acts as one cycle per bit -> 10 cycle frame
    run_frame("ps0", 8'h01, 6'd0, 1'b0, 1'b0, {1'b1, 8'h01, 1'b0}, 10);

    // Odd prescale, different pattern
    run_frame("ps3", 8'h3A, 6'd3, 1'b0, 1'b0, {1'b1, 8'h3A, 1'b0}, 10);

`ifdef STIM_RX_DRV_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0; 11 x 16 = 176
    run_frame("par_even", 8'h07, 6'd16, 1'b1, 1'b0, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    run_frame("par_odd",  8'h07, 6'd16, 1'b1, 1'b1, {1'b1, 1'b0, 8'h07, 1'b0}, 11);
    run_frame("par_off",  8'h55, 6'd8,  1'b0, 1'b1, {1'b1, 8'h55, 1'b0}, 10);
`else
    // PAR_EN ignored without the parity build: 80 cycles, no parity bit
    run_frame("nopar", 8'h55, 6'd8, 1'b1, 1'b0, {1'b1, 8'h55, 1'b0}, 10);
`endif

    // Back-to-back with TX_VLD held high: frame 0x3C, one idle cycle, frame 0xC3
    ef1 = {1'b1, 8'h3C, 1'b0};
    ef2 = {1'b1, 8'hC3, 1'b0};
    @(negedge REF_CLK);
    TX_IN = 8'h3C; PRESCALE = 6'd4; PAR_EN = 1'b0; PAR_TYP = 1'b0; TX_VLD = 1'b1;
    @(negedge REF_CLK);
    for (int k = 0; k < 90; k++) begin
      line_s[k] = S_DATA; busy_s[k] = BUSY; done_s[k] = DONE;
      if (k == 5)  TX_IN = 8'hC3;
      if (k == 50) TX_IN = 8'h00;
      if (k == 70) TX_VLD = 1'b0;
      @(negedge REF_CLK);
    end
    bad = 0; dn = 0;
    for (int k = 0; k < 81; k++) begin
      if (k < 40) begin
        if (line_s[k] !== ef1[k / 4]) bad++;
      end else if (k == 40) begin
        if (line_s[k] !== 1'b1) bad++;
      end else begin
        if (line_s[k] !== ef2[(k - 41) / 4]) bad++;
      end
    end
    for (int k = 0; k < 90; k++) if (done_s[k]) dn++;
    check_eq("b2b_bit_errs", bad, 0);
    check_eq("b2b_done1", done_s[39], 1);
    check_eq("b2b_gap_busy", busy_s[40], 0);
    check_eq("b2b_busy2", busy_s[41], 1);
    check_eq("b2b_done2", done_s[80], 1);
    check_eq("b2b_end_busy", busy_s[81], 0);
    check_eq("b2b_done_cnt", dn, 2);

    // Reset during DATA bit 3 of frame 0xFF aborts without DONE
    @(negedge REF_CLK);
    TX_IN = 8'hFF; PRESCALE = 6'd4; TX_VLD = 1'b1;
    @(negedge REF_CLK);
    TX_VLD = 1'b0;
    repeat (17) @(negedge REF_CLK);
    check_eq("abort_pre_busy", BUSY, 1);
    check_eq("abort_pre_line", S_DATA, 1);
    RST_REF = 1'b1;
    @(negedge REF_CLK);
    check_eq("abort_line", S_DATA, 1);
    check_eq("abort_busy", BUSY, 0);
    check_eq("abort_done", DONE, 0);
    RST_REF = 1'b0;
    dn = 0; bz = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge REF_CLK);
      if (DONE) dn++;
      if (BUSY) bz++;
    end
    check_eq("abort_no_done", dn, 0);
    check_eq("abort_stays_idle", bz, 0);
    run_frame("post_rst", 8'h96, 6'd5, 1'b0, 1'b0, {1'b1, 8'h96, 1'b0}, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stim_rx_drv.md
STIM_RX_DRV -- requirements
Module: stim_rx_drv

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, as the payload bits per frame.
REQ-002 The block SHALL take parameter PRESCALE_W, default 6, as the width of the PRESCALE input.
REQ-003 Port REF_CLK, input, 1 bit, SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port RST_REF, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-005 Port TX_IN, input, DATA_WIDTH bits, SHALL be the payload to serialize.
REQ-006 Port TX_VLD, input, 1 bit, SHALL be the load request for TX_IN.
REQ-007 Port PRESCALE, input, PRESCALE_W bits, SHALL give the REF_CLK cycles per serial bit.
REQ-008 Port PAR_EN, input, 1 bit, SHALL enable the parity bit.
REQ-009 Port PAR_TYP, input, 1 bit, SHALL select parity: 0 even, 1 odd.
REQ-010 Port S_DATA, output, 1 bit, SHALL be the serial line driven toward the DUT RX_IN.
REQ-011 Port BUSY, output, 1 bit, SHALL be high while a frame is in progress.
REQ-012 Port DONE, output, 1 bit, SHALL be a one-cycle pulse at frame end.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 In IDLE, S_DATA SHALL be 1 and BUSY 0; TX_VLD=1 SHALL latch TX_IN, PRESCALE, PAR_EN and PAR_TYP, then go to START on the next edge.
REQ-015 TX_VLD SHALL be ignored while BUSY=1; no queueing, no corruption of the latched frame.
REQ-016 BUSY SHALL rise on the edge after TX_VLD is accepted and fall on the edge DONE pulses.
REQ-017 Each bit state SHALL hold S_DATA for exactly the latched PRESCALE cycles; a bit counter SHALL count 0 to PRESCALE-1, then advance.
REQ-018 START SHALL drive 0; DATA SHALL drive latched bits LSB first, DATA_WIDTH bits; STOP SHALL drive 1.
REQ-019 PARITY SHALL be entered only when the latched PAR_EN=1; it SHALL drive XOR of the data bits, inverted when PAR_TYP=1.
REQ-020 Frame length SHALL be (DATA_WIDTH+2) x PRESCALE cycles, or (DATA_WIDTH+3) x PRESCALE with parity.
REQ-021 DONE SHALL pulse for one cycle on the last cycle of STOP; the FSM SHALL return to IDLE on the next edge.
REQ-022 TX_VLD high in that DONE cycle SHALL be ignored; a request in the following cycle SHALL be accepted, giving back-to-back frames with one idle cycle of S_DATA=1.
REQ-023 A latched PRESCALE of 0 SHALL be treated as 1.
REQ-024 Input changes after latching SHALL NOT affect the frame in progress.

Reset
REQ-025 RST_REF=1 at a rising edge SHALL force: state IDLE, S_DATA 1, BUSY 0, DONE 0, and all counters and latches 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately, with no DONE pulse; S_DATA SHALL be 1 from the next edge.

Configuration
REQ-027 Macro STIM_RX_DRV_PARITY_EN defined: PAR_EN and PAR_TYP SHALL behave as in REQ-008, REQ-009 and REQ-019.
REQ-028 Macro STIM_RX_DRV_PARITY_EN undefined: the PARITY state and parity logic SHALL be absent; PAR_EN and PAR_TYP SHALL stay as ports but be ignored; frames SHALL never carry parity.

Structure
REQ-029 A shared package stim_rx_pkg SHALL hold the FSM state enum and the constants IDLE_LEVEL=1, START_LEVEL=0 and STOP_LEVEL=1.
REQ-030 The bit timer SHALL be sub-module stim_bit_tmr (load, PRESCALE in, bit_end pulse out); the FSM, shift register and parity stay in stim_rx_drv.

Verification
REQ-031 PRESCALE=8, PAR_EN=0, TX_IN=0xA5, one TX_VLD pulse -> S_DATA = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; DONE high exactly 80 cycles after BUSY rises.
REQ-032 PRESCALE=16, PAR_EN=1, PAR_TYP=0, TX_IN=0x07 -> parity bit 1, frame 176 cycles; with PAR_TYP=1 -> parity bit 0.
REQ-033 TX_VLD held high continuously with TX_IN=0x3C then 0xC3 -> two complete frames separated by one idle cycle; TX_IN changes mid-frame do not alter the bits sent.
REQ-034 RST_REF=1 during DATA bit 3 of frame 0xFF -> next cycle S_DATA=1, BUSY=0, no DONE; a new TX_VLD afterward sends a clean frame.
REQ-035 PRESCALE=0, TX_IN=0x01 -> each bit lasts 1 cycle, 10-cycle frame.
REQ-036 Build without STIM_RX_DRV_PARITY_EN, PAR_EN=1, TX_IN=0x55, PRESCALE=8 -> 80-cycle frame with no parity bit.
